// File: rtl/fpga_top_pkg.sv
// Shared constants for the FPGA top level: reset-sequencer state encoding
// and default staged-release timing.
package fpga_top_pkg;

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_STAGGER = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    typedef enum logic [1:0] {
        ASSERT  = ST_ASSERT,
        HOLD    = ST_HOLD,
        STAGGER = ST_STAGGER,
        RUN     = ST_RUN
    } seq_state_e;

    localparam int CORE_HOLD_DEF = 16;
    localparam int IO_DELAY_DEF  = 4;
    localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/reset_sequencer.sv
// Staged reset release: the FP adder core comes out of reset first, the I/O
// side IO_DELAY cycles later; a ready flag and completion counter aid debug.
module reset_sequencer
    import fpga_top_pkg::*;
#(
    parameter int CORE_HOLD = CORE_HOLD_DEF,
    parameter int IO_DELAY  = IO_DELAY_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    output logic       rst_core,
    output logic       rst_io,
    output logic       ready,
    output logic       seq_done,
    output logic [7:0] seq_count
);

    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_HOLD - 1);
    localparam logic [CNT_W-1:0] IO_LAST   = CNT_W'(IO_DELAY - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_core_q, rst_core_d;
    logic             rst_io_q, rst_io_d;
    logic             ready_q, ready_d;
    logic             seq_done_q, seq_done_d;
    // Cleared only by configuration, never by reset, so it survives restarts.
    logic [7:0]       seq_count_q = 8'd0;
    logic [7:0]       seq_count_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_core_d  = rst_core_q;
        rst_io_d    = rst_io_q;
        ready_d     = ready_q;
        seq_done_d  = 1'b0;
        seq_count_d = seq_count_q;
        case (state_q)
            ASSERT: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                if (cnt_q == CORE_LAST) begin
                    rst_core_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = STAGGER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STAGGER: begin
                if (cnt_q == IO_LAST) begin
                    rst_io_d    = 1'b0;
                    ready_d     = 1'b1;
                    seq_done_d  = 1'b1;
                    seq_count_d = seq_count_q + 8'd1;
                    cnt_d       = '0;
                    state_d     = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ASSERT;
            cnt_q      <= '0;
            rst_core_q <= 1'b1;
            rst_io_q   <= 1'b1;
            ready_q    <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_core_q <= rst_core_d;
            rst_io_q   <= rst_io_d;
            ready_q    <= ready_d;
            seq_done_q <= seq_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seq_count_q <= seq_count_d;
        end
    end

    assign rst_core  = rst_core_q;
    assign rst_io    = rst_io_q;
    assign ready     = ready_q;
    assign seq_done  = seq_done_q;
    assign seq_count = seq_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected output vectors are queued per
// edge from the release timeline and compared #1 after each rising edge.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_a = 1'b1;
    logic       reset_b = 1'b1;
    logic       rst_core_a, rst_io_a, ready_a, seq_done_a;
    logic       rst_core_b, rst_io_b, ready_b, seq_done_b;
    logic [7:0] seq_count_a, seq_count_b;

    logic [11:0] exp_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          done_pulses_a = 0;
    logic [7:0]  cnt_a = 8'd0;
    logic [7:0]  cnt_b = 8'd0;
    string       phase = "reset";

    always #5 clk = ~clk;

    reset_sequencer #(.CORE_HOLD(4), .IO_DELAY(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset_a), .rst_core(rst_core_a), .rst_io(rst_io_a),
        .ready(ready_a), .seq_done(seq_done_a), .seq_count(seq_count_a)
    );

    reset_sequencer #(.CORE_HOLD(1), .IO_DELAY(1), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset_b), .rst_core(rst_core_b), .rst_io(rst_io_b),
        .ready(ready_b), .seq_done(seq_done_b), .seq_count(seq_count_b)
    );

    // One edge: drive reset, queue the expected post-edge vector, compare.
    task automatic tick(input bit sel, input logic r, input logic [11:0] e);
        logic [11:0] obs;
        logic [11:0] want;
        if (sel) reset_b = r; else reset_a = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs = sel ? {rst_core_b, rst_io_b, ready_b, seq_done_b, seq_count_b}
                  : {rst_core_a, rst_io_a, ready_a, seq_done_a, seq_count_a};
        want = exp_q.pop_front();
        if (!sel && obs[8]) done_pulses_a++;
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: {core,io,ready,done,count} got %h want %h", phase, obs, want);
        end
        vectors++;
        assert (!(obs[10] === 1'b0 && obs[11] !== 1'b0)) else begin
            errors++;
            $error("FAIL %s invariant: rst_io=%b rst_core=%b required rst_core=0", phase, obs[10], obs[11]);
        end
    endtask

    task automatic hold_reset(input bit sel, input int n);
        for (int i = 0; i < n; i++)
            tick(sel, 1'b1, {1'b1, 1'b1, 1'b0, 1'b0, sel ? cnt_b : cnt_a});
    endtask

    // Edges E0..E(n-1) with reset low: core releases at E(ch), io at E(ch+io).
    task automatic run_release(input bit sel, input int ch, input int io, input int n);
        for (int k = 0; k < n; k++) begin
            if (k == ch + io) begin
                if (sel) cnt_b = cnt_b + 8'd1; else cnt_a = cnt_a + 8'd1;
            end
            tick(sel, 1'b0, {k < ch, k < ch + io, k >= ch + io, k == ch + io,
                             sel ? cnt_b : cnt_a});
        end
    endtask

    initial begin
        int start_pulses;
        logic [7:0] start_cnt;

        phase = "s1_nominal";
        hold_reset(0, 5);
        run_release(0, 4, 2, 9);

        phase = "s2_reset_in_hold";
        hold_reset(0, 2);
        run_release(0, 4, 2, 2);
        hold_reset(0, 1);
        run_release(0, 4, 2, 9);

        phase = "s3_reset_in_stagger";
        hold_reset(0, 1);
        run_release(0, 4, 2, 5);
        hold_reset(0, 1);
        run_release(0, 4, 2, 9);

        phase = "s4_pulse_in_run";
        hold_reset(0, 1);
        run_release(0, 4, 2, 9);

        phase = "s5_wrap";
        start_pulses = done_pulses_a;
        start_cnt    = cnt_a;
        for (int s = 0; s < 256; s++) begin
            hold_reset(0, 1);
            run_release(0, 4, 2, 7);
        end
        vectors++;
        assert (done_pulses_a - start_pulses == 256) else begin
            errors++;
            $error("FAIL s5_pulse_count: got %0d want 256", done_pulses_a - start_pulses);
        end
        vectors++;
        assert (seq_count_a === start_cnt) else begin
            errors++;
            $error("FAIL s5_wrap_count: got %0d want %0d", seq_count_a, start_cnt);
        end

        phase = "s6_min_timing";
        hold_reset(1, 3);
        run_release(1, 1, 1, 5);
        hold_reset(1, 1);
        run_release(1, 1, 1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
